// File: rtl/ssd1306_spi_receiver.sv
// Display-side SSD1306 4-wire SPI receiver: shadows panel configuration and drives a framebuffer port.
// Define SPI_RX_SYNC_EN to pass the serial inputs through 2-FF synchronizers (latency N+3 instead of N+1).
module ssd1306_spi_receiver #(
    parameter logic [7:0] DEFAULT_CONTRAST  = 8'h7F,
    parameter logic [1:0] DEFAULT_ADDR_MODE = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_sclk,
    input  logic       io_sdin,
    input  logic       io_cs,
    input  logic       io_dc,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       display_on,
    output logic       invert,
    output logic [7:0] contrast,
    output logic [1:0] addr_mode,
    output logic       charge_pump_on
);

    typedef enum logic {CMD_IDLE, CMD_ARG} cmd_state_t;

    // Input bundle order: {sclk, sdin, cs, dc}; cs resets to its inactive level.
    logic [3:0] in_s;
    logic [3:0] in_r;
    logic       sclk_d;

`ifdef SPI_RX_SYNC_EN
    logic [3:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'b0010;
            sync2 <= 4'b0010;
        end else begin
            sync1 <= {io_sclk, io_sdin, io_cs, io_dc};
            sync2 <= sync1;
        end
    end

    assign in_s = sync2;
`else
    assign in_s = {io_sclk, io_sdin, io_cs, io_dc};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r   <= 4'b0010;
            sclk_d <= 1'b0;
        end else begin
            in_r   <= in_s;
            sclk_d <= in_r[3];
        end
    end

    logic       sclk_rise;
    logic [7:0] new_byte;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    cmd_state_t state;
    logic [7:0] opcode;
    logic [1:0] arg_left;
    logic [2:0] page;
    logic [6:0] col;

    assign sclk_rise = in_r[3] & ~sclk_d & ~in_r[1];
    assign new_byte  = {shift_reg, in_r[2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg      <= '0;
            bit_cnt        <= '0;
            rx_valid       <= 1'b0;
            rx_byte        <= '0;
            rx_dc          <= 1'b0;
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_wdata       <= '0;
            display_on     <= 1'b0;
            invert         <= 1'b0;
            contrast       <= DEFAULT_CONTRAST;
            addr_mode      <= DEFAULT_ADDR_MODE;
            charge_pump_on <= 1'b0;
            state          <= CMD_IDLE;
            opcode         <= '0;
            arg_left       <= '0;
            page           <= '0;
            col            <= '0;
        end else begin
            rx_valid <= 1'b0;
            fb_we    <= 1'b0;
            if (in_r[1]) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= new_byte[6:0];
                if (bit_cnt != 3'd7) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    bit_cnt  <= '0;
                    rx_valid <= 1'b1;
                    rx_byte  <= new_byte;
                    rx_dc    <= in_r[0];
                    if (in_r[0]) begin
                        // A data byte also cancels any pending command argument.
                        state    <= CMD_IDLE;
                        arg_left <= '0;
                        fb_we    <= 1'b1;
                        fb_wdata <= new_byte;
                        fb_addr  <= {page, col};
                        case (addr_mode)
                            2'b00: begin
                                col <= col + 7'd1;
                                if (col == 7'd127) page <= page + 3'd1;
                            end
                            2'b01: begin
                                page <= page + 3'd1;
                                if (page == 3'd7) col <= col + 7'd1;
                            end
                            default: col <= col + 7'd1;
                        endcase
                    end else if (state == CMD_ARG) begin
                        case (opcode)
                            8'h81: contrast <= new_byte;
                            8'h20: if (new_byte[1:0] != 2'b11) addr_mode <= new_byte[1:0];
                            8'h8D: charge_pump_on <= new_byte[2];
                            default: ;
                        endcase
                        if (arg_left == 2'd2) begin
                            arg_left <= 2'd1;
                        end else begin
                            arg_left <= '0;
                            state    <= CMD_IDLE;
                        end
                    end else begin
                        case (new_byte) inside
                            8'hAE: display_on <= 1'b0;
                            8'hAF: display_on <= 1'b1;
                            8'hA6: invert     <= 1'b0;
                            8'hA7: invert     <= 1'b1;
                            8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                                state    <= CMD_ARG;
                                opcode   <= new_byte;
                                arg_left <= 2'd1;
                            end
                            8'h21, 8'h22: begin
                                state    <= CMD_ARG;
                                opcode   <= new_byte;
                                arg_left <= 2'd2;
                            end
                            [8'hB0:8'hB7]: page      <= new_byte[2:0];
                            [8'h00:8'h0F]: col[3:0]  <= new_byte[3:0];
                            [8'h10:8'h17]: col[6:4]  <= new_byte[2:0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Scoreboard bench for ssd1306_spi_receiver: stimulus pushes expected bytes, a monitor checks each strobe.
module tb_ssd1306_spi_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_sclk, io_sdin, io_cs, io_dc;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       display_on, invert, charge_pump_on;
    logic [7:0] contrast;
    logic [1:0] addr_mode;

    ssd1306_spi_receiver #(.DEFAULT_CONTRAST(8'h7F), .DEFAULT_ADDR_MODE(2'b10)) dut (
        .clk(clk), .rst(rst),
        .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_dc(rx_dc),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .display_on(display_on), .invert(invert), .contrast(contrast),
        .addr_mode(addr_mode), .charge_pump_on(charge_pump_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        logic       we;
        logic [9:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    int   n_pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            exp_t e;
            n_strobe++;
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'(rx_byte), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("rx_byte", 32'(rx_byte), 32'(e.b));
                check("rx_dc", 32'(rx_dc), 32'(e.dc));
                check("fb_we", 32'(fb_we), 32'(e.we));
                if (e.we) begin
                    check("fb_addr", 32'(fb_addr), 32'(e.addr));
                    check("fb_wdata", 32'(fb_wdata), 32'(e.b));
                end
            end
        end else if (fb_we === 1'b1) begin
            check("fb_we_without_valid", 32'(fb_we), 32'd0);
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic d, input int unsigned n);
        io_cs = 1'b0;
        for (int i = 7; i > 7 - int'(n); i--) begin
            @(negedge clk); io_sclk = 1'b0; io_sdin = b[i]; io_dc = d;
            @(negedge clk); io_sclk = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic d, input logic we, input logic [9:0] a);
        exp_t e;
        e.b = b; e.dc = d; e.we = we; e.addr = a;
        q.push_back(e);
        n_pushed++;
        send_bits(b, d, 8);
    endtask

    task automatic cmd(input logic [7:0] b);
        xfer(b, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        check({tag, "_rx_byte"}, 32'(rx_byte), 32'd0);
        check({tag, "_rx_dc"}, 32'(rx_dc), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
        check({tag, "_display_on"}, 32'(display_on), 32'd0);
        check({tag, "_invert"}, 32'(invert), 32'd0);
        check({tag, "_contrast"}, 32'(contrast), 32'h7F);
        check({tag, "_addr_mode"}, 32'(addr_mode), 32'd2);
        check({tag, "_charge_pump"}, 32'(charge_pump_on), 32'd0);
    endtask

    logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h01, 8'hC8, 8'h40, 8'hA1,
                                  8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB,
                                  8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};

    initial begin
        rst = 1'b1; io_sclk = 1'b0; io_sdin = 1'b0; io_cs = 1'b1; io_dc = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Init sequence: commands only, no framebuffer writes.
        foreach (init_seq[i]) cmd(init_seq[i]);
        settle();
        check("init_strobes", 32'(n_strobe), 32'd23);
        check("init_contrast", 32'(contrast), 32'h7F);
        check("init_addr_mode", 32'(addr_mode), 32'd1);
        check("init_charge_pump", 32'(charge_pump_on), 32'd1);
        check("init_display_on", 32'(display_on), 32'd1);
        check("init_invert", 32'(invert), 32'd0);

        // Vertical fill: page advances first, column after page 7; wraps after 1024 bytes.
        for (int k = 0; k < 1025; k++) begin
            logic [9:0] a;
            a = 10'((((k % 8) << 7) | ((k / 8) % 128)));
            xfer(8'(k % 256), 1'b1, 1'b1, a);
        end

        // Horizontal mode from {page 0, col 0}.
        cmd(8'h20); cmd(8'h00); cmd(8'hB0); cmd(8'h00); cmd(8'h10);
        for (int k = 0; k < 129; k++) xfer(8'(k ^ 8'h5A), 1'b1, 1'b1, 10'(k));
        settle();
        check("horiz_addr_mode", 32'(addr_mode), 32'd0);

        // Page mode: page 3, col 0x15; addr_mode 11 must be ignored.
        cmd(8'h20); cmd(8'h02); cmd(8'hB3); cmd(8'h05); cmd(8'h11);
        cmd(8'h20); cmd(8'h03);
        xfer(8'hC1, 1'b1, 1'b1, 10'h195);
        xfer(8'hC2, 1'b1, 1'b1, 10'h196);
        settle();
        check("page_addr_mode_kept", 32'(addr_mode), 32'd2);

        // Aborted byte: 5 bits then chip-select high discards the partial byte.
        send_bits(8'hFF, 1'b0, 5);
        @(negedge clk); io_sclk = 1'b0; io_cs = 1'b1;
        repeat (2) @(negedge clk);
        cmd(8'hA7);
        settle();
        check("abort_invert", 32'(invert), 32'd1);

        // Interrupted argument: data byte during CMD_ARG is written, contrast kept.
        cmd(8'h81); cmd(8'h55);
        settle();
        check("contrast_set", 32'(contrast), 32'h55);
        cmd(8'h81);
        xfer(8'h3C, 1'b1, 1'b1, 10'h197);
        settle();
        check("interrupt_contrast", 32'(contrast), 32'h55);
        cmd(8'h42);
        settle();
        check("interrupt_idle_contrast", 32'(contrast), 32'h55);

        // Same again, with reset after bit 4 of the data byte.
        cmd(8'h81);
        send_bits(8'h3C, 1'b1, 4);
        @(negedge clk); rst = 1'b1; io_sclk = 1'b0; io_cs = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("postreset");
        xfer(8'h99, 1'b1, 1'b1, 10'h000);

        begin
            int unsigned budget = 100;
            while (q.size() != 0 && budget != 0) begin
                @(negedge clk);
                budget--;
            end
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        check("strobe_total", 32'(n_strobe), 32'(n_pushed));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd1306_spi_receiver.md
# ssd1306_spi_receiver

Display-side end of the 4-wire SSD1306 serial link: receives the MSB-first byte stream that the display controller drives on `io_sclk`/`io_sdin`/`io_cs`/`io_dc`. Command bytes are decoded into a shadow copy of the panel's configuration. Data bytes are written into a 1024-byte framebuffer port with SSD1306 address auto-increment. The block is the on-chip mirror and scoreboard target for the display path, both in simulation and in loopback on the FPGA.

## Interface
- `DEFAULT_CONTRAST`, 8'h7F: value of `contrast` after reset.
- `DEFAULT_ADDR_MODE`, 2'b10: value of `addr_mode` after reset (00 horizontal, 01 vertical, 10 page).

- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `io_sclk` input 1: serial clock. Data is sampled on its rising edge.
- `io_sdin` input 1: serial data, MSB first.
- `io_cs` input 1: chip select, active-low.
- `io_dc` input 1: 0 = command byte, 1 = data byte. Sampled with bit 0.
- `rx_valid` output 1: one-cycle strobe when a byte is complete.
- `rx_byte` output 8: last received byte.
- `rx_dc` output 1: D/C value of the last byte.
- `fb_we` output 1: framebuffer write strobe.
- `fb_addr` output 10: `{page[2:0], col[6:0]}`.
- `fb_wdata` output 8: framebuffer write data.
- `display_on` output 1: set by AF, cleared by AE.
- `invert` output 1: set by A7, cleared by A6.
- `contrast` output 8: argument of command 81.
- `addr_mode` output 2: argument of command 20.
- `charge_pump_on` output 1: argument bit 2 of command 8D.

## Operation
- **Bit capture.**
  - A rising edge of `io_sclk` while `io_cs`=0 shifts `io_sdin` into an 8-bit shift register and increments a 3-bit bit counter.
  - On the 8th bit: latch `rx_byte` and `rx_dc` (`io_dc` sampled at the same edge), pulse `rx_valid`, and clear the bit counter.
- **Chip select.** While `io_cs`=1, the bit counter is held at 0 and a partial byte is discarded. `io_cs` going high between bytes is normal operation.
- **Command parser** (`dc`=0 bytes). States CMD_IDLE, CMD_ARG.
  - AE/AF/A6/A7 act immediately.
  - 81, 20, 8D, A8, D3, D5, D9, DA, DB go to CMD_ARG and record the opcode.
  - In CMD_ARG the next command byte is the argument. 81 loads `contrast`. 20 loads `addr_mode` (value 11 is ignored and the mode is kept). 8D loads `charge_pump_on` = arg[2]. The other opcodes are consumed and ignored. Return to CMD_IDLE.
  - B0–B7 set `page` = byte[2:0].
  - 00–0F set `col[3:0]`; 10–17 set `col[6:4]`.
  - 21/22 consume 2 arguments and are ignored (CMD_ARG entered with a count of 2).
  - Any other opcode is ignored.
  - A data byte received in CMD_ARG aborts the argument: return to CMD_IDLE and process the byte as data.
- **Data path** (`dc`=1 bytes).
  - `fb_we`=1, `fb_wdata`=byte, `fb_addr`={page,col}.
  - Then advance the pointer:
    - Horizontal mode: col+1. At col 127, col wraps to 0 and page increments; page 7 wraps to 0.
    - Vertical mode: page+1. At page 7, page wraps to 0 and col increments; col 127 wraps to 0.
    - Page mode: col+1, wrapping 127→0, with page unchanged.
- **Reset values.**
  - `rx_valid`, `fb_we`, `rx_byte`, `rx_dc`, `fb_addr`, `fb_wdata` = 0.
  - page = col = 0, `display_on` = 0, `invert` = 0, `charge_pump_on` = 0.
  - `contrast` = `DEFAULT_CONTRAST`, `addr_mode` = `DEFAULT_ADDR_MODE`, parser in CMD_IDLE, bit counter = 0.
- **Reset mid-byte.** Asserting `rst` mid-byte discards the partial byte. No strobe is emitted.

## Timing
- Each `io_sclk` level must be held for ≥1 `clk` cycle if driven from `clk`, or ≥3 cycles if asynchronous.
- `io_sdin` and `io_dc` must be stable at the sampled rising edge.
- Let N be the first `clk` edge at which `io_sclk`=1 is sampled for bit 0.
  - `rx_valid` is high for exactly one cycle, after edge N+3 (with synchronizers) or N+1 (without).
- `fb_we` and `fb_addr`/`fb_wdata` are valid in the same cycle as `rx_valid`. The pointer advance is visible on the next byte.
- Configuration outputs update in the same cycle as `rx_valid` of the completing byte.
- Back-to-back bytes at 2 `clk` per bit are sustained: 16 cycles per byte.
- A `rst` deasserted mid-stream causes the receiver to resynchronise on the next `io_cs` high.

## Configuration
- `SPI_RX_SYNC_EN` defined:
  - `io_sclk`, `io_sdin`, `io_cs`, `io_dc` each pass through a 2-FF synchronizer before edge detection.
  - All four inputs are delayed equally.
  - Latency is N+3.
- `SPI_RX_SYNC_EN` not defined:
  - Inputs are registered once for edge detection only.
  - Latency is N+1.
  - The driver must share `clk`.

## Test plan
- **Init sequence.** Send the 23-byte sequence AE 81 7F A6 20 01 C8 40 A1 A8 3F D3 00 D5 80 D9 22 DB 20 8D 14 A4 AF with `dc`=0. Required: 23 `rx_valid` pulses, no `fb_we`, `contrast`=7F, `addr_mode`=01, `charge_pump_on`=1, `display_on`=1.
- **Vertical-mode fill.** After init, send 1025 data bytes with values 0..255 repeating. Required: `fb_addr` sequence 000, 080, 100, …, 380, 001, 081, …; byte 1024 at 3FF; byte 1025 wraps to 000.
- **Horizontal mode.** Send 20 00 then 129 data bytes. Required: addresses 000..07F, then 080.
- **Page mode.** Send 20 02, B3, 05, 11, then 2 data bytes. Required: `fb_addr` 195 then 196.
- **Aborted byte.** Drive 5 bits, raise `io_cs` for 2 cycles, then send a full byte A7. Required: exactly one `rx_valid`, `rx_byte`=A7, `invert`=1.
- **Interrupted argument.** Send 81 (`dc`=0) then 3C (`dc`=1). Required: `contrast` unchanged, `fb_we` with `fb_wdata`=3C. Repeat with `rst` asserted after bit 4. Required: no strobe, all outputs at reset values.
